// File: rtl/hexbox_pkg.sv
// Shared constants, types and helpers for the hexbox renderer and its scheduler.
package hexbox_pkg;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

    typedef logic [31:0] hex_word_t;

    // MSB index of a hexbox x coordinate spanning cols glyphs.
    function automatic int hexbox_xbits(input int cols);
        return $clog2(cols * GLYPH_W) - 1;
    endfunction

endpackage

// File: rtl/hexbox_row_slot.sv
// One row's value storage and update handshake.
// HEXBOX_SCHEDULER_TEAR_GUARD_EN adds a pending buffer committed on frame_start.
module hexbox_row_slot
    import hexbox_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      upd_valid,
    input  hex_word_t upd_value,
`ifdef HEXBOX_SCHEDULER_TEAR_GUARD_EN
    input  logic      frame_start,
`endif
    output logic      upd_ready,
    output hex_word_t active
);

    hex_word_t active_q, active_d;

`ifdef HEXBOX_SCHEDULER_TEAR_GUARD_EN
    hex_word_t pending_q, pending_d;
    logic      pend_vld_q, pend_vld_d;

    assign upd_ready = !pend_vld_q;

    // Accept and commit are exclusive: accept needs the pending slot empty.
    always_comb begin
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        if (frame_start && pend_vld_q) begin
            active_d   = pending_q;
            pend_vld_d = 1'b0;
        end
        if (upd_valid && !pend_vld_q) begin
            pending_d  = upd_value;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
        end
    end
`else
    assign upd_ready = 1'b1;

    always_comb begin
        active_d = active_q;
        if (upd_valid) active_d = upd_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active_q <= '0;
        else        active_q <= active_d;
    end
`endif

    assign active = active_q;

endmodule

// File: rtl/hexbox_scheduler.sv
// Time-shares one hexbox renderer across ROWS stacked 32-bit values.
// HEXBOX_SCHEDULER_TEAR_GUARD_EN enables frame-start double buffering.
module hexbox_scheduler
    import hexbox_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 8,
    parameter int XBITS  = hexbox_xbits(COLS),
    parameter int PXBITS = 11,
    parameter int PYBITS = 10,
    parameter int X0     = 0,
    parameter int Y0     = 0,
    parameter int HB_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWS-1:0]        upd_valid,
    input  logic [ROWS-1:0][31:0]  upd_value,
    output logic [ROWS-1:0]        upd_ready,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [PXBITS-1:0]      pix_x,
    input  logic [PYBITS-1:0]      pix_y,
    output logic [31:0]            hx_value,
    output logic [XBITS:0]         hx_x,
    output logic [3:0]             hx_y,
    input  logic                   hx_pixel,
    output logic                   pixel_out,
    output logic                   pixel_valid_out
);

    // One extra bit so window edges never wrap.
    localparam logic [PXBITS:0] XLo = (PXBITS+1)'(X0);
    localparam logic [PXBITS:0] XHi = (PXBITS+1)'(X0 + COLS * GLYPH_W);
    localparam logic [PYBITS:0] YLo = (PYBITS+1)'(Y0);
    localparam logic [PYBITS:0] YHi = (PYBITS+1)'(Y0 + ROWS * GLYPH_H);

    hex_word_t active [ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_slot
        hexbox_row_slot u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .upd_valid   (upd_valid[r]),
            .upd_value   (upd_value[r]),
`ifdef HEXBOX_SCHEDULER_TEAR_GUARD_EN
            .frame_start (frame_start),
`endif
            .upd_ready   (upd_ready[r]),
            .active      (active[r])
        );
    end

    logic [PXBITS:0] px, dx;
    logic [PYBITS:0] py, dy;
    logic [3:0]      row;
    logic            inwin;
    hex_word_t       row_val;

    assign px    = {1'b0, pix_x};
    assign py    = {1'b0, pix_y};
    assign dx    = px - XLo;
    assign dy    = py - YLo;
    assign row   = dy[7:4];
    assign inwin = pix_valid && (px >= XLo) && (px < XHi) && (py >= YLo) && (py < YHi);

    always_comb begin
        row_val = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row == 4'(r)) row_val = active[r];
        end
    end

    hex_word_t        hx_value_q, hx_value_d;
    logic [XBITS:0]   hx_x_q, hx_x_d;
    logic [3:0]       hx_y_q, hx_y_d;
    logic [HB_LAT:0]  inwin_sr_q, inwin_sr_d;
    logic [HB_LAT:0]  vld_sr_q, vld_sr_d;
    logic             pixel_out_q, pixel_out_d;
    logic             pixel_valid_out_q, pixel_valid_out_d;

    // Bit 0 aligns with hx_* (N+1); bit HB_LAT aligns with hx_pixel.
    always_comb begin
        hx_value_d = hx_value_q;
        hx_x_d     = hx_x_q;
        hx_y_d     = hx_y_q;
        if (inwin) begin
            hx_value_d = row_val;
            hx_x_d     = dx[XBITS:0];
            hx_y_d     = dy[3:0];
        end
        inwin_sr_d        = {inwin_sr_q[HB_LAT-1:0], inwin};
        vld_sr_d          = {vld_sr_q[HB_LAT-1:0], pix_valid};
        pixel_out_d       = hx_pixel & inwin_sr_q[HB_LAT] & vld_sr_q[HB_LAT];
        pixel_valid_out_d = vld_sr_q[HB_LAT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hx_value_q        <= '0;
            hx_x_q            <= '0;
            hx_y_q            <= '0;
            inwin_sr_q        <= '0;
            vld_sr_q          <= '0;
            pixel_out_q       <= 1'b0;
            pixel_valid_out_q <= 1'b0;
        end else begin
            hx_value_q        <= hx_value_d;
            hx_x_q            <= hx_x_d;
            hx_y_q            <= hx_y_d;
            inwin_sr_q        <= inwin_sr_d;
            vld_sr_q          <= vld_sr_d;
            pixel_out_q       <= pixel_out_d;
            pixel_valid_out_q <= pixel_valid_out_d;
        end
    end

    assign hx_value        = hx_value_q;
    assign hx_x            = hx_x_q;
    assign hx_y            = hx_y_q;
    assign pixel_out       = pixel_out_q;
    assign pixel_valid_out = pixel_valid_out_q;

`ifdef HEXBOX_SCHEDULER_TEAR_GUARD_EN
    logic unused_bits;
    assign unused_bits = ^{dx[PXBITS:XBITS+1], dy[PYBITS:8]};
`else
    logic unused_bits;
    assign unused_bits = ^{dx[PXBITS:XBITS+1], dy[PYBITS:8], frame_start};
`endif

endmodule
